// File: rtl/fft_pkg.sv
// Shared fixed-point definitions for the butterfly datapaths: Q1.15 complex words and scaling helpers.
// Optional macro IBFU_ROUND_EN selects round-half-up in half_add (truncation otherwise).
package fft_pkg;

    localparam int CX_W   = 32;
    localparam int HALF_W = 16;
    localparam int FRAC_W = 15;

    localparam logic [HALF_W-1:0] Q15_MAX = 16'h7FFF;
    localparam logic [HALF_W-1:0] Q15_MIN = 16'h8000;

    typedef struct packed {
        logic signed [HALF_W-1:0] im;
        logic signed [HALF_W-1:0] re;
    } cx_t;

    // Picks bits [30:15] of a 33-bit product sum, clamping to Q1.15 when sat_en is set.
    function automatic logic [HALF_W-1:0] sat16(input logic signed [32:0] v, input logic sat_en);
        logic [HALF_W-1:0] r;
        logic              ovf;
        ovf = (v[32:30] != 3'b000) && (v[32:30] != 3'b111);
        if (sat_en && ovf) begin
            if (v[32]) begin
                r = Q15_MIN;
            end else begin
                r = Q15_MAX;
            end
        end else begin
            r = v[30:15];
        end
        return r;
    endfunction

    // Half of (a +/- b) in 17-bit precision; the >>>1 keeps the result inside 16 bits.
    function automatic logic [HALF_W-1:0] half_add(input logic signed [HALF_W-1:0] a,
                                                   input logic signed [HALF_W-1:0] b,
                                                   input logic                     sub);
        logic signed [HALF_W:0] t;
        if (sub) begin
            t = {a[HALF_W-1], a} - {b[HALF_W-1], b};
        end else begin
            t = {a[HALF_W-1], a} + {b[HALF_W-1], b};
        end
`ifdef IBFU_ROUND_EN
        t = t + 17'sd1;
`else
        t = t + 17'sd0;
`endif
        return t[HALF_W:1];
    endfunction

endpackage

// File: rtl/ibfu_pipe_if.sv
// Handshake and data bundle of the inverse butterfly: input pair + twiddle, recovered output pair.
interface ibfu_pipe_if;

    logic                     in_valid;
    logic                     in_ready;
    logic [fft_pkg::CX_W-1:0] in_x;
    logic [fft_pkg::CX_W-1:0] in_y;
    logic [fft_pkg::CX_W-1:0] twiddle_factor;
    logic                     out_valid;
    logic                     out_ready;
    logic [fft_pkg::CX_W-1:0] out_a;
    logic [fft_pkg::CX_W-1:0] out_b;

    modport master (
        output in_valid, in_x, in_y, twiddle_factor, out_ready,
        input  in_ready, out_valid, out_a, out_b
    );

    modport slave (
        input  in_valid, in_x, in_y, twiddle_factor, out_ready,
        output in_ready, out_valid, out_a, out_b
    );

endinterface

// File: rtl/cx_conj_multiplier.sv
// Three-stage d * conj(w) multiplier (products, sums, scale/saturate) with per-stage load enables.
// Optional macro IBFU_ROUND_EN adds 2^14 before the final bit select.
module cx_conj_multiplier
    import fft_pkg::*;
#(
    parameter bit SAT = 1'b1
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [2:0] ld,
    input  logic       vin,
    input  cx_t        d,
    input  cx_t        w,
    output logic [2:0] vout,
    output cx_t        prod
);

`ifdef IBFU_ROUND_EN
    localparam logic signed [32:0] RND_S4 = 33'sd16384;
`else
    localparam logic signed [32:0] RND_S4 = 33'sd0;
`endif

    logic               v2_r, v3_r, v4_r;
    logic signed [31:0] pr1_s, pr2_s, pr3_s, pr4_s;
    logic signed [31:0] pr1_r, pr2_r, pr3_r, pr4_r;
    logic signed [32:0] re_s, im_s;
    logic signed [32:0] re3_r, im3_r;
    cx_t                res_s;

    // Stage-local arithmetic: products from the inputs, sums from S2, scaled result from S3.
    always_comb begin
        pr1_s = d.re * w.re;
        pr2_s = d.im * w.im;
        pr3_s = d.im * w.re;
        pr4_s = d.re * w.im;
        re_s  = $signed({pr1_r[31], pr1_r}) + $signed({pr2_r[31], pr2_r});
        im_s  = $signed({pr3_r[31], pr3_r}) - $signed({pr4_r[31], pr4_r});
        res_s.re = sat16(re3_r + RND_S4, SAT);
        res_s.im = sat16(im3_r + RND_S4, SAT);
    end

    // S2: partial products of d and conj(w).
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            v2_r  <= 1'b0;
            pr1_r <= '0;
            pr2_r <= '0;
            pr3_r <= '0;
            pr4_r <= '0;
        end else if (ld[0]) begin
            v2_r <= vin;
            if (vin) begin
                pr1_r <= pr1_s;
                pr2_r <= pr2_s;
                pr3_r <= pr3_s;
                pr4_r <= pr4_s;
            end
        end
    end

    // S3: full-precision real/imag sums.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            v3_r  <= 1'b0;
            re3_r <= '0;
            im3_r <= '0;
        end else if (ld[1]) begin
            v3_r <= v2_r;
            if (v2_r) begin
                re3_r <= re_s;
                im3_r <= im_s;
            end
        end
    end

    // S4: Q1.15 result register, doubles as the block's output register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            v4_r <= 1'b0;
            prod <= '0;
        end else if (ld[2]) begin
            v4_r <= v3_r;
            if (v3_r) begin
                prod <= res_s;
            end
        end
    end

    assign vout = {v4_r, v3_r, v2_r};

endmodule

// File: rtl/ibfu_pipe.sv
// Inverse radix-2 butterfly: a = (x+y)/2, b = ((x-y)/2)*conj(w), 4-stage valid/ready pipeline.
// Optional macro IBFU_ROUND_EN enables round-half-up at both scaling points.
module ibfu_pipe
    import fft_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter bit SAT     = 1'b1
) (
    input  logic          clk,
    input  logic          clear_n,
    ibfu_pipe_if.slave    bus
);

    if (LATENCY != 4) begin : g_bad_latency
        $error("ibfu_pipe: LATENCY must be 4");
    end

    logic       v1_r;
    cx_t        s1_r, d1_r, w1_r;
    cx_t        s2_r, s3_r, s4_r;
    cx_t        x_s, y_s, s_s, d_s;
    cx_t        prod_s;
    logic [2:0] mvalid_s;
    logic [3:0] load_s;

    // Stage k loads when empty or when the stage after it loads, so bubbles collapse.
    always_comb begin
        load_s[3] = !mvalid_s[2] || bus.out_ready;
        load_s[2] = !mvalid_s[1] || load_s[3];
        load_s[1] = !mvalid_s[0] || load_s[2];
        load_s[0] = !v1_r || load_s[1];
    end

    // S1 half-sum/half-difference of the incoming pair.
    always_comb begin
        x_s  = cx_t'(bus.in_x);
        y_s  = cx_t'(bus.in_y);
        s_s.re = half_add(x_s.re, y_s.re, 1'b0);
        s_s.im = half_add(x_s.im, y_s.im, 1'b0);
        d_s.re = half_add(x_s.re, y_s.re, 1'b1);
        d_s.im = half_add(x_s.im, y_s.im, 1'b1);
    end

    // S1 register: s, d and the twiddle captured on an input transfer.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            v1_r <= 1'b0;
            s1_r <= '0;
            d1_r <= '0;
            w1_r <= '0;
        end else if (load_s[0]) begin
            v1_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_r <= s_s;
                d1_r <= d_s;
                w1_r <= cx_t'(bus.twiddle_factor);
            end
        end
    end

    // s rides alongside the multiplier stages with identical load conditions.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            s2_r <= '0;
            s3_r <= '0;
            s4_r <= '0;
        end else begin
            if (load_s[1] && v1_r) begin
                s2_r <= s1_r;
            end
            if (load_s[2] && mvalid_s[0]) begin
                s3_r <= s2_r;
            end
            if (load_s[3] && mvalid_s[1]) begin
                s4_r <= s3_r;
            end
        end
    end

    cx_conj_multiplier #(
        .SAT (SAT)
    ) u_mult (
        .clk     (clk),
        .clear_n (clear_n),
        .ld      (load_s[3:1]),
        .vin     (v1_r),
        .d       (d1_r),
        .w       (w1_r),
        .vout    (mvalid_s),
        .prod    (prod_s)
    );

    assign bus.in_ready  = load_s[0];
    assign bus.out_valid = mvalid_s[2];
    assign bus.out_a     = s4_r;
    assign bus.out_b     = prod_s;

endmodule
